mc_main_ctrl: RTL
=================

Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the project-2 MIPS-subset core.
- Decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the datapath muxes and enables, and supplies the 2-bit ALUOp consumed by the ALU control decoder (funct-driven).
- Holds in memory states until the memory handshake completes.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction bits [31:26] from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write qualifier for mem_req.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load qualified by ALU zero.
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=use funct, 11=and.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- illegal_op  out  1  sticky: unsupported opcode decoded.
- instr_done  out  1  one-cycle pulse on each instruction completion.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100, J 000010.
- State register asynchronously reset to S_RESET.
- S_RESET lasts one cycle after rst_n deasserts, then goes to S_FETCH.
- In S_RESET all outputs are 0; retired=0 and illegal_op=0.
- Outputs are Moore (decoded from state). Exceptions: ir_write and pc_write in S_FETCH are gated by mem_ready.
- Any output not listed for a state is 0.

States and transitions:
- S_FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. When mem_ready=1: ir_write=1, pc_write=1, go to S_DECODE. Otherwise hold; PC and IR are unchanged.
- S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - LW or SW -> S_MEMADR
  - RTYPE -> S_EXEC
  - BEQ -> S_BRANCH
  - ADDI or ANDI -> S_IEXEC
  - J -> S_JUMP
  - any other opcode -> set illegal_op, go to S_FETCH (instruction skipped, not counted).
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to S_MEMRD for LW, S_MEMWR for SW.
- S_MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to S_MEMWB.
- S_MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Completes -> S_FETCH.
- S_MEMWR: mem_req=1, mem_write=1, iord=1. Hold until mem_ready; completes on mem_ready -> S_FETCH.
- S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> S_ALUWB.
- S_ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Completes -> S_FETCH.
- S_IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI or 11 for ANDI -> S_IWB.
- S_IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Completes -> S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01. Completes -> S_FETCH.
- S_JUMP: pc_write=1, pc_src=10. Completes -> S_FETCH.

Completion and counters:
- On every completion: instr_done=1 in that cycle; retired increments at the following clock edge and wraps modulo 2^CNT_W.

Latencies excluding memory wait cycles:
- LW 5, SW 4, R-type 4, ADDI/ANDI 4, BEQ 3, J 3.

Boundary conditions:
- mem_ready is ignored outside S_FETCH, S_MEMRD and S_MEMWR.
- mem_req and mem_write stay stable while waiting.
- illegal_op clears only on reset.
- Reset mid-instruction: immediate return to S_RESET; no partial enables assert after reset.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode constants
  - ALUOp encodings (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10, ALU_AND=11)
  - alu_src_b and pc_src encodings
- No sub-module: next-state logic, output decode and counter live in one module. The ALU control decoder is instantiated by the datapath, not here.

Test Plan:
- Reset then opcode=000000, mem_ready=1 always -> states FETCH, DECODE, EXEC, ALUWB; alu_op=10 in EXEC; reg_write=1 with reg_dst=1 in ALUWB; instr_done pulse; retired=1.
- LW with mem_ready low for 2 cycles in S_FETCH and 3 in S_MEMRD -> mem_req held with iord 0 then 1; ir_write and pc_write exactly once; 10 cycles total; mem_to_reg=1 in writeback.
- BEQ -> S_BRANCH shows alu_op=01, branch=1, pc_src=01; SW -> mem_write=1 only in S_MEMWR; J -> pc_write=1, pc_src=10.
- ANDI then ADDI -> alu_op=11 then 00 in S_IEXEC; alu_src_b=10; reg_dst=0; retired increments by 2.
- opcode=111111 -> illegal_op rises after DECODE and stays 1; FSM back to FETCH; retired unchanged.
- rst_n low during S_MEMRD -> all outputs 0 immediately; retired=0; after release, S_RESET one cycle then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset main controller.
// Opcodes, FSM state enum and datapath mux select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StIExec,
    StIWb,
    StBranch,
    StJump
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and counts retired instructions.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;

    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        // PC and IR only load on the cycle the fetch actually returns.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:     state_d = StMemAdr;
          OP_RTYPE:         state_d = StExec;
          OP_BEQ:           state_d = StBranch;
          OP_ADDI, OP_ANDI: state_d = StIExec;
          OP_J:             state_d = StJump;
          default: begin
            illegal_d = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        branch     = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    retired_d = retired_q + CNT_W'(instr_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReset;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal_op = illegal_q;
  assign retired    = retired_q;

endmodule
